// File: rtl/exec_pkg.sv
// Purpose : shared op-class encodings, FSM state enum, latency defaults and helpers.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package exec_pkg;

    // Circuit-select values that identify the special op classes.
    localparam logic [9:0] SEL_MUL = 10'b00_1000_0000;
    localparam logic [9:0] SEL_DIV = 10'b00_0000_1000;
    localparam logic [9:0] SEL_CMP = 10'b00_0000_0000;

    // Issue-to-GR-write latencies.
    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 34;
    localparam int ALU_LAT_DEF = 2;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_ALU = 2'd0,
        OP_MUL = 2'd1,
        OP_DIV = 2'd2,
        OP_CMP = 2'd3
    } op_class_e;

    function automatic op_class_e op_class(input logic [9:0] sel);
        op_class_e cls;
        if (sel == SEL_MUL) begin
            cls = OP_MUL;
        end else if (sel == SEL_DIV) begin
            cls = OP_DIV;
        end else if (sel == SEL_CMP) begin
            cls = OP_CMP;
        end else begin
            cls = OP_ALU;
        end
        return cls;
    endfunction

    // One-hot scoreboard mask for a GR; r0 is hardwired and never tracked.
    function automatic logic [31:0] reg_mask(input logic [4:0] r);
        logic [31:0] m;
        m = '0;
        if (r != 5'd0) begin
            m[r] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/exec_wb_pipe.sv
// Purpose : write-back tracking pipe for single-cycle ops; emits the pending-clear for a GR.
// Latency : entry pushed on a transfer edge is presented on clr_* DEPTH cycles later.
// Backpressure: none; one push per cycle accepted unconditionally.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push_i            an ALU op transferred this cycle
//   push_dest_i       its destination GR
//   clr_vld_o         oldest entry leaves the pipe this cycle
//   clr_dest_o        GR whose pending bit is cleared
//
// DEPTH is ALU_LAT-1: the transfer cycle itself is the first stage of the
// ALU latency, so the register stages cover the remainder. DEPTH must be >= 1.
module exec_wb_pipe #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [4:0] push_dest_i,
    output logic       clr_vld_o,
    output logic [4:0] clr_dest_o
);

    logic [DEPTH-1:0] vld_q;
    logic [4:0]       dest_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= push_i;
            dest_q[0] <= push_dest_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                dest_q[i] <= dest_q[i-1];
            end
        end
    end

    assign clr_vld_o  = vld_q[DEPTH-1];
    assign clr_dest_o = dest_q[DEPTH-1];

endmodule

// File: rtl/exec_issue_ctrl.sv
// Purpose : decoder-to-executer issue control with GR scoreboard and MUL/DIV wait FSM.
// Latency : issue outputs registered, valid the cycle after a transfer.
// Backpressure: dec_ready_o low on any GR hazard or while a MUL/DIV is in flight.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   dec_valid_i / dec_ready_o          decoder handshake
//   dec_sel_i, dec_dest_i, dec_dest2_i, dec_src1_i, dec_src2_i, dec_use_i   op fields
//   ex_issue_o, ex_sel_o, ex_dest_o, ex_dest2_o                             executer issue
//   busy_o                             MUL/DIV in flight
//   done_o                             one-cycle pulse when MUL/DIV completes
//   pending_o                          GR write-outstanding scoreboard
module exec_issue_ctrl
    import exec_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int ALU_LAT = ALU_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid_i,
    output logic        dec_ready_o,
    input  logic [9:0]  dec_sel_i,
    input  logic [4:0]  dec_dest_i,
    input  logic [4:0]  dec_dest2_i,
    input  logic [4:0]  dec_src1_i,
    input  logic [4:0]  dec_src2_i,
    input  logic [1:0]  dec_use_i,
    output logic        ex_issue_o,
    output logic [9:0]  ex_sel_o,
    output logic [4:0]  ex_dest_o,
    output logic [4:0]  ex_dest2_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] pending_o
);

    op_class_e   cls;
    logic        is_md;
    logic        hazard;
    logic        xfer;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        wait_done;

    logic [31:0] pend_q, pend_d;
    logic [31:0] set_mask, clr_mask;
    logic [4:0]  wdest_q, wdest2_q;

    logic        ex_issue_q;
    logic [9:0]  ex_sel_q;
    logic [4:0]  ex_dest_q, ex_dest2_q;

    logic        pipe_clr_vld;
    logic [4:0]  pipe_clr_dest;

    // ------------------------------------------------------------------
    // Decode and hazard check
    // ------------------------------------------------------------------
    assign cls   = op_class(dec_sel_i);
    assign is_md = (cls == OP_MUL) || (cls == OP_DIV);

    // RAW on sources, WAW on destinations; dest2 only matters for MUL/DIV.
    assign hazard = (dec_use_i[0] & pend_q[dec_src1_i])
                  | (dec_use_i[1] & pend_q[dec_src2_i])
                  | pend_q[dec_dest_i]
                  | (is_md & pend_q[dec_dest2_i]);

    assign dec_ready_o = (state_q == ST_RUN) && !hazard;
    assign xfer        = dec_valid_i && dec_ready_o;

    // ------------------------------------------------------------------
    // MUL/DIV wait FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_done = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (xfer && (cls == OP_MUL)) begin
                    state_d = ST_MUL_WAIT;
                    cnt_d   = 6'(MUL_LAT - 1);
                end else if (xfer && (cls == OP_DIV)) begin
                    state_d = ST_DIV_WAIT;
                    cnt_d   = 6'(DIV_LAT - 1);
                end
            end
            ST_MUL_WAIT, ST_DIV_WAIT: begin
                if (cnt_q == 6'd0) begin
                    state_d   = ST_RUN;
                    wait_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            wdest_q  <= '0;
            wdest2_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Remember which GRs the in-flight MUL/DIV will release.
            if (xfer && is_md) begin
                wdest_q  <= dec_dest_i;
                wdest2_q <= dec_dest2_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Single-cycle op write-back tracking
    // ------------------------------------------------------------------
    exec_wb_pipe #(
        .DEPTH (ALU_LAT - 1)
    ) u_wb_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (xfer && (cls == OP_ALU)),
        .push_dest_i (dec_dest_i),
        .clr_vld_o   (pipe_clr_vld),
        .clr_dest_o  (pipe_clr_dest)
    );

    // ------------------------------------------------------------------
    // Scoreboard: set on transfer, clear on write-back; a set beats a
    // coincident clear of the same bit. reg_mask never selects r0.
    // ------------------------------------------------------------------
    always_comb begin
        set_mask = '0;
        if (xfer) begin
            case (cls)
                OP_ALU:         set_mask = reg_mask(dec_dest_i);
                OP_MUL, OP_DIV: set_mask = reg_mask(dec_dest_i) | reg_mask(dec_dest2_i);
                default:        set_mask = '0;
            endcase
        end

        clr_mask = '0;
        if (pipe_clr_vld) begin
            clr_mask = clr_mask | reg_mask(pipe_clr_dest);
        end
        if (wait_done) begin
            clr_mask = clr_mask | reg_mask(wdest_q) | reg_mask(wdest2_q);
        end

        pend_d = (pend_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered issue to the executer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_issue_q <= 1'b0;
            ex_sel_q   <= '0;
            ex_dest_q  <= '0;
            ex_dest2_q <= '0;
        end else begin
            ex_issue_q <= xfer;
            ex_sel_q   <= xfer ? dec_sel_i   : 10'd0;
            ex_dest_q  <= xfer ? dec_dest_i  : 5'd0;
            ex_dest2_q <= xfer ? dec_dest2_i : 5'd0;
        end
    end

    assign ex_issue_o = ex_issue_q;
    assign ex_sel_o   = ex_sel_q;
    assign ex_dest_o  = ex_dest_q;
    assign ex_dest2_o = ex_dest2_q;
    assign busy_o     = (state_q != ST_RUN);
    assign done_o     = wait_done;
    assign pending_o  = pend_q;

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Bench for exec_issue_ctrl: directed scenarios plus random op stream,
// checked against a cycle-time reference model through a scoreboard.
module tb_exec_issue_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 34;
    localparam int ALU_LAT = 2;

    localparam logic [9:0] S_MUL = 10'h080;
    localparam logic [9:0] S_DIV = 10'h008;
    localparam logic [9:0] S_CMP = 10'h000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dec_valid_i;
    logic        dec_ready_o;
    logic [9:0]  dec_sel_i;
    logic [4:0]  dec_dest_i, dec_dest2_i, dec_src1_i, dec_src2_i;
    logic [1:0]  dec_use_i;
    logic        ex_issue_o;
    logic [9:0]  ex_sel_o;
    logic [4:0]  ex_dest_o, ex_dest2_o;
    logic        busy_o, done_o;
    logic [31:0] pending_o;

    exec_issue_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .ALU_LAT (ALU_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dec_valid_i (dec_valid_i),
        .dec_ready_o (dec_ready_o),
        .dec_sel_i   (dec_sel_i),
        .dec_dest_i  (dec_dest_i),
        .dec_dest2_i (dec_dest2_i),
        .dec_src1_i  (dec_src1_i),
        .dec_src2_i  (dec_src2_i),
        .dec_use_i   (dec_use_i),
        .ex_issue_o  (ex_issue_o),
        .ex_sel_o    (ex_sel_o),
        .ex_dest_o   (ex_dest_o),
        .ex_dest2_o  (ex_dest2_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pending_o   (pending_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    // Expected issue: cycle in which ex_issue_o is high, plus its payload.
    typedef struct {
        int         c;
        logic [9:0] sel;
        logic [4:0] d;
        logic [4:0] d2;
    } iss_t;

    // Busy/pending interval [s, e); r == 32 denotes busy_o.
    typedef struct {
        int r;
        int s;
        int e;
    } ivl_t;

    iss_t iq[$];
    int   dq[$];
    ivl_t ivq[$];
    int   free_at[32];
    int   fsm_free;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    endfunction

    // ------------------------------------------------------------------
    // Monitor: compares DUT outputs against the scoreboard every cycle.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [31:0] exp_p;
        logic        exp_b;
        logic        exp_d;
        logic        exp_i;
        exp_p = '0;
        exp_b = 1'b0;
        foreach (ivq[k]) begin
            if (ivq[k].s <= cyc && cyc < ivq[k].e) begin
                if (ivq[k].r == 32) exp_b = 1'b1;
                else exp_p[ivq[k].r] = 1'b1;
            end
        end
        chk("pending_o", 64'(pending_o), 64'(exp_p));
        chk("busy_o", 64'(busy_o), 64'(exp_b));

        exp_d = (dq.size() > 0) && (dq[0] == cyc);
        chk("done_o", 64'(done_o), 64'(exp_d));
        if (exp_d) void'(dq.pop_front());

        exp_i = (iq.size() > 0) && (iq[0].c == cyc);
        chk("ex_issue_o", 64'(ex_issue_o), 64'(exp_i));
        if (exp_i) begin
            chk("ex_sel_o", 64'(ex_sel_o), 64'(iq[0].sel));
            chk("ex_dest_o", 64'(ex_dest_o), 64'(iq[0].d));
            chk("ex_dest2_o", 64'(ex_dest2_o), 64'(iq[0].d2));
            void'(iq.pop_front());
        end else begin
            chk("ex_sel_o idle", 64'(ex_sel_o), 64'd0);
        end

        for (int k = ivq.size() - 1; k >= 0; k--) begin
            if (ivq[k].e <= cyc) ivq.delete(k);
        end
    end

    // ------------------------------------------------------------------
    // Driver + reference model. Called at negedge+#1 of the cycle in
    // which the op is first offered.
    // ------------------------------------------------------------------
    task automatic send(input logic [9:0] sel, input logic [4:0] d, input logic [4:0] d2,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [1:0] u);
        int  t;
        int  lat;
        int  n;
        bit  md;
        md = (sel == S_MUL) || (sel == S_DIV);
        // Accept cycle: first cycle at which no needed register is outstanding
        // and no MUL/DIV is occupying the controller.
        t = cyc;
        if (fsm_free > t) t = fsm_free;
        if (u[0] && free_at[s1] > t) t = free_at[s1];
        if (u[1] && free_at[s2] > t) t = free_at[s2];
        if (free_at[d] > t) t = free_at[d];
        if (md && free_at[d2] > t) t = free_at[d2];

        iq.push_back('{t + 1, sel, d, d2});
        if (md) begin
            lat = (sel == S_MUL) ? MUL_LAT : DIV_LAT;
            fsm_free = t + lat + 1;
            dq.push_back(t + lat);
            ivq.push_back('{32, t + 1, t + lat + 1});
            if (d != 0) begin
                free_at[d] = t + lat + 1;
                ivq.push_back('{int'(d), t + 1, t + lat + 1});
            end
            if (d2 != 0) begin
                free_at[d2] = t + lat + 1;
                ivq.push_back('{int'(d2), t + 1, t + lat + 1});
            end
        end else if (sel != S_CMP && d != 0) begin
            free_at[d] = t + ALU_LAT;
            ivq.push_back('{int'(d), t + 1, t + ALU_LAT});
        end

        dec_sel_i   = sel;
        dec_dest_i  = d;
        dec_dest2_i = d2;
        dec_src1_i  = s1;
        dec_src2_i  = s2;
        dec_use_i   = u;
        dec_valid_i = 1'b1;
        #1;
        n = 0;
        while (!dec_ready_o && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!dec_ready_o) begin
            n_chk++;
            $display("FAIL accept_timeout cycle %0d: got ready 0 expected acceptance by cycle %0d", cyc, t);
        end
        @(negedge clk);
        #1;
        dec_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    logic [9:0] alu_sels [8];
    initial begin
        logic [9:0] sel;
        int         r;
        alu_sels = '{10'h001, 10'h002, 10'h004, 10'h010, 10'h020, 10'h040, 10'h100, 10'h200};
        dec_valid_i = 1'b0;
        dec_sel_i   = '0;
        dec_dest_i  = '0;
        dec_dest2_i = '0;
        dec_src1_i  = '0;
        dec_src2_i  = '0;
        dec_use_i   = '0;
        for (int i = 0; i < 32; i++) free_at[i] = 0;
        fsm_free = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset ex_issue_o", 64'(ex_issue_o), 64'd0);
        chk("reset ex_sel_o", 64'(ex_sel_o), 64'd0);
        chk("reset ex_dest_o", 64'(ex_dest_o), 64'd0);
        chk("reset ex_dest2_o", 64'(ex_dest2_o), 64'd0);
        chk("reset busy_o", 64'(busy_o), 64'd0);
        chk("reset done_o", 64'(done_o), 64'd0);
        chk("reset pending_o", 64'(pending_o), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // RAW on r3 after an ALU write to r3
        send(10'h001, 5'd3, 5'd0, 5'd1, 5'd2, 2'b11);
        send(10'h001, 5'd3, 5'd0, 5'd3, 5'd2, 2'b01);
        idle(3);

        // MUL r4/r5, then a dependent and an independent op
        send(S_MUL, 5'd4, 5'd5, 5'd1, 5'd2, 2'b11);
        send(10'h002, 5'd6, 5'd0, 5'd4, 5'd0, 2'b01);
        idle(3);

        // DIV: controller stays closed for the whole divide
        send(S_DIV, 5'd6, 5'd7, 5'd1, 5'd2, 2'b11);
        send(10'h004, 5'd8, 5'd0, 5'd11, 5'd12, 2'b11);
        idle(3);

        // Ten independent ALU ops back-to-back
        for (int i = 1; i <= 10; i++)
            send(10'h010, 5'(i), 5'd0, 5'(i + 16), 5'(i + 16), 2'b01);
        idle(3);

        // r0 write then r0 read: no stall
        send(10'h020, 5'd0, 5'd0, 5'd1, 5'd2, 2'b00);
        send(10'h020, 5'd11, 5'd0, 5'd0, 5'd0, 2'b11);
        idle(2);

        // dest == dest2 on MUL, then reuse of that register
        send(S_MUL, 5'd9, 5'd9, 5'd0, 5'd0, 2'b00);
        send(10'h040, 5'd12, 5'd0, 5'd9, 5'd0, 2'b01);
        idle(3);

        // Random stream with a small register window to provoke hazards
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 19);
            if (r < 2) sel = S_CMP;
            else if (r < 5) sel = S_MUL;
            else if (r < 6) sel = S_DIV;
            else sel = alu_sels[$urandom_range(0, 7)];
            send(sel, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(40);

        // Reset in the tenth cycle of a DIV wait
        send(S_DIV, 5'd6, 5'd7, 5'd0, 5'd0, 2'b00);
        idle(9);
        rst_n = 1'b0;
        iq.delete();
        dq.delete();
        ivq.delete();
        for (int i = 0; i < 32; i++) free_at[i] = 0;
        fsm_free = 0;
        #1;
        chk("async reset pending_o", 64'(pending_o), 64'd0);
        chk("async reset busy_o", 64'(busy_o), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        dec_sel_i   = 10'h001;
        dec_dest_i  = 5'd6;
        dec_dest2_i = 5'd0;
        dec_src1_i  = 5'd7;
        dec_src2_i  = 5'd0;
        dec_use_i   = 2'b01;
        dec_valid_i = 1'b1;
        #1;
        chk("dec_ready_o after reset", 64'(dec_ready_o), 64'd1);
        send(10'h001, 5'd6, 5'd0, 5'd7, 5'd0, 2'b01);
        idle(60);

        chk("issue queue drained", 64'(iq.size()), 64'd0);
        chk("done queue drained", 64'(dq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
